vx_launch_ctrl: RTL and testbench
=================================

// Module: vx_launch_ctrl
// PURPOSE
//  Synthesizable kernel-launch sequencer for the Vortex core. Replays a host-loaded table of DCR
//  writes, holds the core in reset for RESET_DELAY cycles, releases it, and waits for vx_busy to
//  rise and then fall. It then reports done, error and run-cycle count. Sits between host/AXI
//  control registers and the core's dcr_wr_* / vx_reset / vx_busy pins.
// PARAMETERS
//  DCR_ADDR_W    12  DCR address width
//  DCR_DATA_W    32  DCR data width
//  NUM_DCRS      4   DCR table depth (entries); >=1
//  RESET_DELAY   8   cycles vx_reset is held high after DCR replay; >=1
//  BUSY_TIMEOUT  256 max cycles to wait for vx_busy rise; 0 = wait forever
//  CYC_W         44  run_cycles width
// PORTS
//  clk          in   1           clock
//  resetn       in   1           reset, synchronous, active-low
//  cfg_wr_valid in   1           append {cfg_wr_addr,cfg_wr_data} to DCR table (IDLE only)
//  cfg_wr_addr  in   DCR_ADDR_W  DCR address to program
//  cfg_wr_data  in   DCR_DATA_W  DCR value
//  cfg_clear    in   1           empty the DCR table (IDLE only)
//  cfg_full     out  1           table holds NUM_DCRS entries
//  start        in   1           launch request, sampled in IDLE only
//  abort        in   1           cancel launch in any state
//  dcr_wr_valid out  1           DCR write strobe to core
//  dcr_wr_addr  out  DCR_ADDR_W  DCR write address
//  dcr_wr_data  out  DCR_DATA_W  DCR write data
//  vx_reset     out  1           core reset, active-high
//  vx_busy      in   1           core busy status
//  active       out  1           state != IDLE
//  done         out  1           one-cycle pulse at launch completion
//  err          out  1           sticky: last launch timed out; cleared on start
//  run_cycles   out  CYC_W       cycles of last/current run; cleared on start
// BEHAVIOUR
//  - Reset values: state=IDLE, table count=0, vx_reset=1, dcr_wr_valid=0, dcr_wr_addr=0,
//    dcr_wr_data=0, done=0, err=0, run_cycles=0, active=0. All outputs are registered.
//  - Table: cfg_wr_valid in IDLE writes entry[count] and increments count. Writes are dropped when
//    count==NUM_DCRS (cfg_full=1) or when state!=IDLE. cfg_clear sets count=0 and wins over a
//    same-cycle cfg_wr_valid.
//  - FSM: IDLE -> DCR_WR -> RST_HOLD -> BUSY_WAIT -> RUN -> DONE -> IDLE.
//  - IDLE: vx_reset=1. If start is seen in cycle T: clear err/run_cycles, go to DCR_WR, or go to
//    RST_HOLD if count==0. A same-cycle cfg write lands first and is included in the replay.
//  - DCR_WR: one entry per cycle, in index order. dcr_wr_valid=1 in cycles T+1..T+N (N=count),
//    with addr/data of entry i in cycle T+1+i. dcr_wr_valid=0 and addr/data=0 otherwise.
//  - RST_HOLD: vx_reset stays 1 for exactly RESET_DELAY cycles. vx_reset drops to 0 in cycle
//    T+N+1+RESET_DELAY.
//  - BUSY_WAIT: on vx_busy=1 go to RUN. If BUSY_TIMEOUT!=0 and BUSY_TIMEOUT cycles pass without
//    vx_busy, set err=1 and go to DONE.
//  - RUN: on vx_busy=0 go to DONE.
//  - DONE: done=1 for one cycle, vx_reset=1 again, return to IDLE next cycle.
//  - run_cycles: +1 every cycle vx_reset=0 (BUSY_WAIT and RUN); saturates at all-ones, no wrap.
//  - abort (highest priority, any non-IDLE state): next cycle state=IDLE, vx_reset=1,
//    dcr_wr_valid=0. No done pulse; err and run_cycles are kept.
//  - start while active=1 is ignored.
//  - resetn low mid-launch: full reset, table emptied.
// TESTING
//  1. Load {0x001,0x80000000},{0x002,0x0}, RESET_DELAY=8; start at T; busy model rises 5 cycles
//     after release, falls 100 cycles later -> dcr writes at T+1,T+2 in order; vx_reset=0 at
//     T+11; done pulses once; run_cycles=105; err=0.
//  2. Empty table, start -> no dcr_wr_valid; vx_reset low exactly RESET_DELAY+1 cycles after
//     start.
//  3. 5 cfg writes with NUM_DCRS=4 -> cfg_full=1 after 4th; 5th dropped; start replays 4 writes.
//  4. BUSY_TIMEOUT=16, vx_busy tied 0 -> done after 16 cycles in BUSY_WAIT; err=1;
//     run_cycles=16; vx_reset=1.
//  5. abort 50 cycles into RUN -> vx_reset=1 next cycle; active=0; no done; second start
//     ignored while active.
//  6. cfg_clear with cfg_wr_valid same cycle -> count=0; start issues no DCR writes.

Source files
------------

// File: rtl/vx_launch_if.sv
// Signal bundle between the launch sequencer, its host control registers
// and the Vortex core DCR/reset/busy pins.
interface vx_launch_if #(
   parameter int DCR_ADDR_W = 12,
   parameter int DCR_DATA_W = 32,
   parameter int CYC_W      = 44
);
   logic                  cfg_wr_valid;
   logic [DCR_ADDR_W-1:0] cfg_wr_addr;
   logic [DCR_DATA_W-1:0] cfg_wr_data;
   logic                  cfg_clear;
   logic                  cfg_full;
   logic                  start;
   logic                  abort;
   logic                  dcr_wr_valid;
   logic [DCR_ADDR_W-1:0] dcr_wr_addr;
   logic [DCR_DATA_W-1:0] dcr_wr_data;
   logic                  vx_reset;
   logic                  vx_busy;
   logic                  active;
   logic                  done;
   logic                  err;
   logic [CYC_W-1:0]      run_cycles;

   modport slave (
      input  cfg_wr_valid, cfg_wr_addr, cfg_wr_data, cfg_clear,
      input  start, abort, vx_busy,
      output cfg_full, dcr_wr_valid, dcr_wr_addr, dcr_wr_data,
      output vx_reset, active, done, err, run_cycles
   );

   modport master (
      output cfg_wr_valid, cfg_wr_addr, cfg_wr_data, cfg_clear,
      output start, abort, vx_busy,
      input  cfg_full, dcr_wr_valid, dcr_wr_addr, dcr_wr_data,
      input  vx_reset, active, done, err, run_cycles
   );
endinterface

// File: rtl/vx_launch_ctrl.sv
// Kernel-launch sequencer: replays the DCR table, pulses core reset,
// then tracks vx_busy through one run and reports done/err/run_cycles.
module vx_launch_ctrl #(
   parameter int DCR_ADDR_W   = 12,
   parameter int DCR_DATA_W   = 32,
   parameter int NUM_DCRS     = 4,
   parameter int RESET_DELAY  = 8,
   parameter int BUSY_TIMEOUT = 256,
   parameter int CYC_W        = 44
) (
   input  logic           clk,
   input  logic           resetn,
   vx_launch_if.slave     bus
);
   localparam logic [2:0] S_IDLE      = 3'd0;
   localparam logic [2:0] S_DCR_WR    = 3'd1;
   localparam logic [2:0] S_RST_HOLD  = 3'd2;
   localparam logic [2:0] S_BUSY_WAIT = 3'd3;
   localparam logic [2:0] S_RUN       = 3'd4;
   localparam logic [2:0] S_DONE      = 3'd5;

   localparam int CNT_W = $clog2(NUM_DCRS + 1);
   localparam int IDX_W = (NUM_DCRS > 1) ? $clog2(NUM_DCRS) : 1;
   localparam int TMR_W = 32;
   localparam logic [CNT_W-1:0] FULL      = CNT_W'(NUM_DCRS);
   localparam logic [TMR_W-1:0] HOLD_LAST = TMR_W'(RESET_DELAY - 1);
   localparam logic [TMR_W-1:0] TO_LAST   = TMR_W'(BUSY_TIMEOUT - 1);

   logic [2:0]            state_q, state_d;
   logic [CNT_W-1:0]      count_q, count_d;
   logic [CNT_W-1:0]      idx_q, idx_d;
   logic [TMR_W-1:0]      tmr_q, tmr_d;
   logic                  vx_reset_q, vx_reset_d;
   logic                  dcr_wr_valid_q, dcr_wr_valid_d;
   logic [DCR_ADDR_W-1:0] dcr_wr_addr_q, dcr_wr_addr_d;
   logic [DCR_DATA_W-1:0] dcr_wr_data_q, dcr_wr_data_d;
   logic                  done_q, done_d;
   logic                  err_q, err_d;
   logic [CYC_W-1:0]      run_cycles_q, run_cycles_d;
   logic                  active_q, active_d;
   logic                  cfg_full_q, cfg_full_d;

   logic [DCR_ADDR_W-1:0] tbl_addr_q [NUM_DCRS];
   logic [DCR_DATA_W-1:0] tbl_data_q [NUM_DCRS];
   logic                  is_idle;
   logic                  tbl_we;
   logic [DCR_ADDR_W-1:0] first_addr;
   logic [DCR_DATA_W-1:0] first_data;

   always_comb begin
      is_idle = (state_q == S_IDLE);
      tbl_we  = is_idle && bus.cfg_wr_valid && !bus.cfg_clear && (count_q != FULL);
      count_d = count_q;
      if (is_idle && bus.cfg_clear)
         count_d = '0;
      else if (tbl_we)
         count_d = count_q + CNT_W'(1);
      // entry 0 may be landing in the same cycle as start
      first_addr = tbl_addr_q[0];
      first_data = tbl_data_q[0];
      if (count_q == '0) begin
         first_addr = bus.cfg_wr_addr;
         first_data = bus.cfg_wr_data;
      end
   end

   always_comb begin
      state_d        = state_q;
      idx_d          = idx_q;
      tmr_d          = tmr_q;
      vx_reset_d     = vx_reset_q;
      dcr_wr_valid_d = 1'b0;
      dcr_wr_addr_d  = '0;
      dcr_wr_data_d  = '0;
      done_d         = 1'b0;
      err_d          = err_q;
      run_cycles_d   = run_cycles_q;
      if (!vx_reset_q && run_cycles_q != '1)
         run_cycles_d = run_cycles_q + CYC_W'(1);
      if (!is_idle && bus.abort) begin
         state_d    = S_IDLE;
         vx_reset_d = 1'b1;
      end else begin
         unique case (state_q)
            S_IDLE: begin
               vx_reset_d = 1'b1;
               if (bus.start) begin
                  err_d        = 1'b0;
                  run_cycles_d = '0;
                  tmr_d        = '0;
                  if (count_d == '0) begin
                     state_d = S_RST_HOLD;
                  end else begin
                     state_d        = S_DCR_WR;
                     dcr_wr_valid_d = 1'b1;
                     dcr_wr_addr_d  = first_addr;
                     dcr_wr_data_d  = first_data;
                     idx_d          = CNT_W'(1);
                  end
               end
            end
            S_DCR_WR: begin
               if (idx_q < count_q) begin
                  dcr_wr_valid_d = 1'b1;
                  dcr_wr_addr_d  = tbl_addr_q[idx_q[IDX_W-1:0]];
                  dcr_wr_data_d  = tbl_data_q[idx_q[IDX_W-1:0]];
                  idx_d          = idx_q + CNT_W'(1);
               end else begin
                  state_d = S_RST_HOLD;
                  tmr_d   = '0;
               end
            end
            S_RST_HOLD: begin
               if (tmr_q == HOLD_LAST) begin
                  state_d    = S_BUSY_WAIT;
                  vx_reset_d = 1'b0;
                  tmr_d      = '0;
               end else begin
                  tmr_d = tmr_q + TMR_W'(1);
               end
            end
            S_BUSY_WAIT: begin
               if (bus.vx_busy) begin
                  state_d = S_RUN;
               end else if (BUSY_TIMEOUT != 0 && tmr_q == TO_LAST) begin
                  state_d    = S_DONE;
                  vx_reset_d = 1'b1;
                  done_d     = 1'b1;
                  err_d      = 1'b1;
               end else begin
                  tmr_d = tmr_q + TMR_W'(1);
               end
            end
            S_RUN: begin
               if (!bus.vx_busy) begin
                  state_d    = S_DONE;
                  vx_reset_d = 1'b1;
                  done_d     = 1'b1;
               end
            end
            S_DONE: state_d = S_IDLE;
            default: begin
               state_d    = S_IDLE;
               vx_reset_d = 1'b1;
            end
         endcase
      end
      active_d   = (state_d != S_IDLE);
      cfg_full_d = (count_d == FULL);
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q        <= S_IDLE;
         count_q        <= '0;
         idx_q          <= '0;
         tmr_q          <= '0;
         vx_reset_q     <= 1'b1;
         dcr_wr_valid_q <= 1'b0;
         dcr_wr_addr_q  <= '0;
         dcr_wr_data_q  <= '0;
         done_q         <= 1'b0;
         err_q          <= 1'b0;
         run_cycles_q   <= '0;
         active_q       <= 1'b0;
         cfg_full_q     <= 1'b0;
      end else begin
         state_q        <= state_d;
         count_q        <= count_d;
         idx_q          <= idx_d;
         tmr_q          <= tmr_d;
         vx_reset_q     <= vx_reset_d;
         dcr_wr_valid_q <= dcr_wr_valid_d;
         dcr_wr_addr_q  <= dcr_wr_addr_d;
         dcr_wr_data_q  <= dcr_wr_data_d;
         done_q         <= done_d;
         err_q          <= err_d;
         run_cycles_q   <= run_cycles_d;
         active_q       <= active_d;
         cfg_full_q     <= cfg_full_d;
      end
   end

   // table storage needs no reset: count_q gates every read
   always_ff @(posedge clk) begin
      if (tbl_we) begin
         tbl_addr_q[count_q[IDX_W-1:0]] <= bus.cfg_wr_addr;
         tbl_data_q[count_q[IDX_W-1:0]] <= bus.cfg_wr_data;
      end
   end

   assign bus.cfg_full     = cfg_full_q;
   assign bus.dcr_wr_valid = dcr_wr_valid_q;
   assign bus.dcr_wr_addr  = dcr_wr_addr_q;
   assign bus.dcr_wr_data  = dcr_wr_data_q;
   assign bus.vx_reset     = vx_reset_q;
   assign bus.active       = active_q;
   assign bus.done         = done_q;
   assign bus.err          = err_q;
   assign bus.run_cycles   = run_cycles_q;
endmodule

// File: tb/tb_vx_launch_ctrl.sv
// Bench for vx_launch_ctrl: launch vectors from a table plus abort and
// mid-launch reset sequences; DCR writes are matched against a queue.
`timescale 1ns/1ps
module tb_vx_launch_ctrl;
   localparam int AW = 12;
   localparam int DW = 32;
   localparam int CW = 44;
   localparam int ND = 4;

   typedef struct {
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
      int            cyc;
   } sb_t;

   typedef struct {
      int n_wr;
      bit clr;
      bit ws;
      int rise;
      int len;
      int exp_run;
      bit exp_err;
   } vec_t;

   logic clk = 1'b0;
   logic resetn = 1'b0;
   logic prev_rst = 1'b1;
   int cyc = 0;
   int checks = 0;
   int errors = 0;
   int done_cnt = 0;
   int rel_first = -1;
   int rel = 0;
   int b_rise = 0;
   int b_len = 0;
   sb_t sb[$];
   logic [AW-1:0] m_addr[$];
   logic [DW-1:0] m_data[$];

   vx_launch_if #(.DCR_ADDR_W(AW), .DCR_DATA_W(DW), .CYC_W(CW)) bus();

   vx_launch_ctrl #(
      .DCR_ADDR_W(AW), .DCR_DATA_W(DW), .NUM_DCRS(ND),
      .RESET_DELAY(8), .BUSY_TIMEOUT(16), .CYC_W(CW)
   ) dut (
      .clk(clk),
      .resetn(resetn),
      .bus(bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // core model: busy for b_len cycles starting on release cycle b_rise
   always @(negedge clk) begin
      if (bus.vx_reset) rel = 0;
      else rel = rel + 1;
      bus.vx_busy = (b_rise != 0) && (rel >= b_rise) && (rel < b_rise + b_len);
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %0h want %0h", nm, act, exp);
      end
   endtask

   task automatic monitor();
      sb_t e;
      forever begin
         @(negedge clk);
         if (resetn && bus.dcr_wr_valid) begin
            checks++;
            if (sb.size() == 0) begin
               errors++;
               $display("FAIL dcr_extra cyc=%0d got %h/%h want none",
                        cyc, bus.dcr_wr_addr, bus.dcr_wr_data);
            end else begin
               e = sb.pop_front();
               if (bus.dcr_wr_addr !== e.addr || bus.dcr_wr_data !== e.data || cyc != e.cyc) begin
                  errors++;
                  $display("FAIL dcr_write got %h/%h@%0d want %h/%h@%0d",
                           bus.dcr_wr_addr, bus.dcr_wr_data, cyc, e.addr, e.data, e.cyc);
               end
            end
         end
         if (bus.done) done_cnt++;
         if (prev_rst && !bus.vx_reset && rel_first < 0) rel_first = cyc;
         prev_rst = bus.vx_reset;
      end
   endtask

   function automatic logic [DW-1:0] ent_data(input int i);
      if (i == 0) return 32'h8000_0000;
      return DW'(i - 1) * 32'h1111_1111;
   endfunction

   task automatic wait_cyc(input int c);
      while (cyc < c) @(negedge clk);
   endtask

   task automatic clear_tbl();
      @(negedge clk);
      bus.cfg_clear = 1'b1;
      m_addr.delete();
      m_data.delete();
   endtask

   task automatic load(input int n, input bit clr_last);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         if (i > 0) chk("cfg_full_step", bus.cfg_full, m_addr.size() == ND);
         bus.cfg_wr_valid = 1'b1;
         bus.cfg_wr_addr  = AW'(i + 1);
         bus.cfg_wr_data  = ent_data(i);
         bus.cfg_clear    = clr_last && (i == n - 1);
         if (bus.cfg_clear) begin
            m_addr.delete();
            m_data.delete();
         end else if (m_addr.size() < ND) begin
            m_addr.push_back(bus.cfg_wr_addr);
            m_data.push_back(bus.cfg_wr_data);
         end
      end
      @(negedge clk);
      bus.cfg_wr_valid = 1'b0;
      bus.cfg_clear    = 1'b0;
      chk("cfg_full_end", bus.cfg_full, m_addr.size() == ND);
   endtask

   task automatic launch(input string nm, input bit ws, input int rise, input int len,
                         input int exp_run, input bit exp_err);
      int t0;
      int n;
      bit got;
      b_rise = rise;
      b_len  = len;
      @(negedge clk);
      bus.start = 1'b1;
      t0 = cyc;
      if (ws) begin
         bus.cfg_wr_valid = 1'b1;
         bus.cfg_wr_addr  = 12'h100;
         bus.cfg_wr_data  = 32'hCAFE_0000;
         if (m_addr.size() < ND) begin
            m_addr.push_back(12'h100);
            m_data.push_back(32'hCAFE_0000);
         end
      end
      n = m_addr.size();
      for (int i = 0; i < n; i++) sb.push_back('{m_addr[i], m_data[i], t0 + 1 + i});
      rel_first = -1;
      done_cnt  = 0;
      @(negedge clk);
      bus.start        = 1'b0;
      bus.cfg_wr_valid = 1'b0;
      got = 1'b0;
      for (int k = 0; k < 2000; k++) begin
         if (bus.done) begin
            got = 1'b1;
            break;
         end
         @(negedge clk);
      end
      chk({nm, "_done_seen"}, got, 1);
      chk({nm, "_err"}, bus.err, exp_err);
      chk({nm, "_run_cycles"}, bus.run_cycles, exp_run);
      chk({nm, "_vx_reset_done"}, bus.vx_reset, 1);
      chk({nm, "_release_cyc"}, rel_first, t0 + n + 9);
      chk({nm, "_dcr_missing"}, sb.size(), 0);
      sb.delete();
      repeat (3) @(negedge clk);
      chk({nm, "_done_once"}, done_cnt, 1);
      chk({nm, "_active_idle"}, bus.active, 0);
   endtask

   initial begin
      vec_t v[7];
      int t0;
      bus.cfg_wr_valid = 1'b0;
      bus.cfg_wr_addr  = '0;
      bus.cfg_wr_data  = '0;
      bus.cfg_clear    = 1'b0;
      bus.start        = 1'b0;
      bus.abort        = 1'b0;
      //        n_wr clr ws rise len run err
      v[0] = '{2, 0, 0, 5, 100, 105, 0};
      v[1] = '{0, 0, 0, 3, 10, 13, 0};
      v[2] = '{5, 0, 0, 2, 20, 22, 0};
      v[3] = '{1, 0, 0, 0, 0, 16, 1};
      v[4] = '{3, 1, 0, 1, 1, 2, 0};
      v[5] = '{1, 0, 1, 7, 3, 10, 0};
      v[6] = '{0, 0, 1, 4, 6, 10, 0};
      fork
         monitor();
      join_none

      repeat (3) @(negedge clk);
      chk("rst_vx_reset", bus.vx_reset, 1);
      chk("rst_dcr_valid", bus.dcr_wr_valid, 0);
      chk("rst_dcr_addr", bus.dcr_wr_addr, 0);
      chk("rst_dcr_data", bus.dcr_wr_data, 0);
      chk("rst_done", bus.done, 0);
      chk("rst_err", bus.err, 0);
      chk("rst_run_cycles", bus.run_cycles, 0);
      chk("rst_active", bus.active, 0);
      chk("rst_cfg_full", bus.cfg_full, 0);
      resetn = 1'b1;

      for (int i = 0; i < 7; i++) begin
         clear_tbl();
         load(v[i].n_wr, v[i].clr);
         launch($sformatf("vec%0d", i), v[i].ws, v[i].rise, v[i].len,
                v[i].exp_run, v[i].exp_err);
      end

      // abort 50 cycles into RUN, with a stray start while active
      clear_tbl();
      load(0, 0);
      b_rise = 1;
      b_len  = 1000;
      done_cnt = 0;
      @(negedge clk);
      bus.start = 1'b1;
      t0 = cyc;
      @(negedge clk);
      bus.start = 1'b0;
      wait_cyc(t0 + 9);
      chk("abort_release", bus.vx_reset, 0);
      wait_cyc(t0 + 29);
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      @(negedge clk);
      chk("abort_start_ignored", bus.active, 1);
      wait_cyc(t0 + 60);
      bus.abort = 1'b1;
      @(negedge clk);
      bus.abort = 1'b0;
      chk("abort_vx_reset", bus.vx_reset, 1);
      chk("abort_active", bus.active, 0);
      chk("abort_dcr_valid", bus.dcr_wr_valid, 0);
      chk("abort_run_cycles", bus.run_cycles, 52);
      repeat (5) @(negedge clk);
      chk("abort_no_done", done_cnt, 0);
      chk("abort_run_kept", bus.run_cycles, 52);

      // resetn mid-run empties the table
      clear_tbl();
      load(4, 0);
      b_rise = 1;
      b_len  = 1000;
      @(negedge clk);
      bus.start = 1'b1;
      t0 = cyc;
      for (int i = 0; i < 4; i++) sb.push_back('{m_addr[i], m_data[i], t0 + 1 + i});
      @(negedge clk);
      bus.start = 1'b0;
      wait_cyc(t0 + 16);
      resetn = 1'b0;
      wait_cyc(t0 + 18);
      chk("mrst_vx_reset", bus.vx_reset, 1);
      chk("mrst_active", bus.active, 0);
      chk("mrst_cfg_full", bus.cfg_full, 0);
      chk("mrst_run_cycles", bus.run_cycles, 0);
      chk("mrst_dcr_replayed", sb.size(), 0);
      sb.delete();
      resetn = 1'b1;
      m_addr.delete();
      m_data.delete();
      launch("post_rst", 0, 3, 4, 7, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
